// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: hazard sources in, per-stage
// write/flush controls and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_write_o;
  logic             id_ex_flush_o;
  logic             ex_mem_write_o;
  logic             mem_wb_flush_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, id_rs1_i, id_rs2_i,
    output ex_memread_i, ex_rd_i,
    output branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o,
    input  id_ex_write_o, id_ex_flush_o,
    input  ex_mem_write_o, mem_wb_flush_o,
    input  err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, id_rs1_i, id_rs2_i,
    input  ex_memread_i, ex_rd_i,
    input  branch_taken_i, mem_req_i, mem_ready_i,
    output pc_write_o, if_id_write_o, if_id_flush_o,
    output id_ex_write_o, id_ex_flush_o,
    output ex_mem_write_o, mem_wb_flush_o,
    output err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline:
// memory wait, load-use and taken-branch arbitration.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(MEM_TIMEOUT - 1);
  localparam bit TO_ONE = (MEM_TIMEOUT == 1);

  state_t           state;
  state_t           state_nx;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_inc;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic halt;
  logic freeze;
  logic load_use;
  logic pc_we;
  logic ifid_we;
  logic ifid_fl;
  logic idex_we;
  logic idex_fl;
  logic exmem_we;
  logic memwb_fl;

  assign halt = rst_i
    | (state == IDLE)
    | (state == ERROR);

  assign freeze = ~hz.mem_ready_i & (
    ((state == RUN) & hz.mem_req_i)
    | (state == MEM_WAIT));

  assign load_use = hz.ex_memread_i
    & (hz.ex_rd_i != 5'd0)
    & ((hz.ex_rd_i == hz.id_rs1_i)
      | (hz.ex_rd_i == hz.id_rs2_i));

  assign to_inc = to_cnt + TO_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (hz.start_i) state_nx = RUN;
      RUN:
        if (freeze)
          state_nx = TO_ONE ? ERROR : MEM_WAIT;
      MEM_WAIT:
        if (hz.mem_ready_i)
          state_nx = RUN;
        else if (to_inc == TO_LAST)
          state_nx = ERROR;
      ERROR:
        state_nx = ERROR;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_we  = 1'b1;
    idex_fl  = 1'b0;
    exmem_we = 1'b1;
    memwb_fl = 1'b0;
    priority case (1'b1)
      halt: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        ifid_fl  = 1'b1;
        idex_fl  = 1'b1;
        memwb_fl = 1'b1;
      end
      freeze: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_fl = 1'b1;
      end
      // a branch seen with load-use re-resolves next cycle
      load_use: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_fl = 1'b1;
      end
      hz.branch_taken_i:
        ifid_fl = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt    <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == MEM_WAIT) && !hz.mem_ready_i)
        to_cnt <= to_inc;
      else
        to_cnt <= '0;
      err <= err | (state == ERROR);
      if (!halt && !pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!halt && ifid_fl && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.pc_write_o     = pc_we;
  assign hz.if_id_write_o  = ifid_we;
  assign hz.if_id_flush_o  = ifid_fl;
  assign hz.id_ex_write_o  = idex_we;
  assign hz.id_ex_flush_o  = idex_fl;
  assign hz.ex_mem_write_o = exmem_we;
  assign hz.mem_wb_flush_o = memwb_fl;
  assign hz.err_o          = err;
  assign hz.stall_cnt_o    = stall_cnt;
  assign hz.flush_cnt_o    = flush_cnt;

endmodule
